// File: rtl/ast_dma_ctrl.sv
// DMA sequencer for CFGDMA: copies words src->dst through the shared data-memory
// port, with CPU priority and a starvation guard that forces periodic DMA grants.
module ast_dma_ctrl #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned LENW       = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            Clock_pin,
  input  logic            Reset_pin,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [AW-1:0]   cfg_src,
  input  logic [AW-1:0]   cfg_dst,
  input  logic [LENW-1:0] cfg_len,
  input  logic            abort,
  input  logic            cpu_mem_req,
  output logic            cpu_grant,
  output logic            dma_mem_en,
  output logic            dma_mem_we,
  output logic [AW-1:0]   dma_mem_addr,
  output logic [DW-1:0]   dma_mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            done,
  output logic [LENW-1:0] xfer_left
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, FIN} state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] data_buf;
  logic [SW-1:0] starve_cnt;
  logic          dma_pending;
  logic          force_grant;
  logic          dma_go;

  // State register
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) state <= IDLE;
    else           state <= state_nx;
  end

  // Next-state logic; abort is honoured only while a copy is in flight
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_valid) state_nx = (cfg_len == '0) ? FIN : RD;
      RD:      if (abort) state_nx = IDLE;
               else if (dma_go) state_nx = RWAIT;
      RWAIT:   state_nx = abort ? IDLE : WR;
      WR:      if (abort) state_nx = IDLE;
               else if (dma_go) state_nx = (xfer_left == LENW'(1)) ? FIN : RD;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port arbitration and state-decoded outputs
  always_comb begin
    cfg_ready     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    dma_pending   = 1'b0;
    force_grant   = 1'b0;
    dma_go        = 1'b0;
    cpu_grant     = cpu_mem_req;
    dma_mem_en    = 1'b0;
    dma_mem_we    = 1'b0;
    dma_mem_addr  = '0;
    dma_mem_wdata = '0;
    if (state == IDLE) begin
      cfg_ready = 1'b1;
      busy      = 1'b0;
    end
    if (state == FIN) done = 1'b1;
    dma_pending = (state == RD) || (state == WR);
    force_grant = (starve_cnt == SW'(STARVE_MAX));
    dma_go      = !cpu_mem_req || force_grant;
    cpu_grant   = cpu_mem_req && !(dma_pending && force_grant);
    dma_mem_en  = dma_pending && dma_go && !abort;
    if (dma_mem_en) begin
      dma_mem_we    = (state == WR);
      dma_mem_addr  = (state == WR) ? dst_addr : src_addr;
      dma_mem_wdata = (state == WR) ? data_buf : '0;
    end
  end

  // Transfer datapath: latched addresses, remaining count and read buffer
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) begin
      src_addr  <= '0;
      dst_addr  <= '0;
      data_buf  <= '0;
      xfer_left <= '0;
    end else begin
      case (state)
        IDLE: if (cfg_valid) begin
          src_addr  <= cfg_src;
          dst_addr  <= cfg_dst;
          xfer_left <= cfg_len;
        end
        RWAIT: if (!abort) data_buf <= mem_rdata;
        WR: if (dma_mem_en) begin
          src_addr  <= src_addr + AW'(1);
          dst_addr  <= dst_addr + AW'(1);
          xfer_left <= xfer_left - LENW'(1);
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: counts blocked DMA cycles, clears on a grant or when idle
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin)                starve_cnt <= '0;
    else if (state == IDLE)       starve_cnt <= '0;
    else if (dma_pending) begin
      if (dma_go)                 starve_cnt <= '0;
      else                        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_ast_dma_ctrl.sv
// Directed bench for ast_dma_ctrl: cycle-by-cycle vector table plus a latency
// sequence and a check of the resulting memory image.
module tb_ast_dma_ctrl;

  typedef struct packed {
    logic        rdy, bsy, dn, gr, en, we;
    logic [15:0] addr, wd;
    logic [7:0]  xl;
  } exp_t;

  typedef struct packed {
    logic        rst, cv;
    logic [15:0] src, dst;
    logic [7:0]  len;
    logic        ab, cr;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_src, cfg_dst;
  logic [7:0]  cfg_len;
  logic        abort;
  logic        cpu_mem_req;
  logic        cpu_grant;
  logic        dma_mem_en, dma_mem_we;
  logic [15:0] dma_mem_addr, dma_mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy, done;
  logic [7:0]  xfer_left;

  int n_checks = 0;
  int n_fail   = 0;

  ast_dma_ctrl dut (
    .Clock_pin(clk), .Reset_pin(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .abort(abort), .cpu_mem_req(cpu_mem_req), .cpu_grant(cpu_grant),
    .dma_mem_en(dma_mem_en), .dma_mem_we(dma_mem_we),
    .dma_mem_addr(dma_mem_addr), .dma_mem_wdata(dma_mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .xfer_left(xfer_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory image; every location not listed reads 0xDEAD
  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hAAAA;
      16'h0011: return 16'hBBBB;
      16'h0012: return 16'hCCCC;
      16'hFFFF: return 16'h1111;
      16'h0000: return 16'h2222;
      16'h0001: return 16'h3333;
      16'h0020: return 16'h5001;
      16'h0021: return 16'h5002;
      default:  return 16'hDEAD;
    endcase
  endfunction

  logic [15:0] mem [65536];
  bit          wr_mask [65536];

  function automatic logic [15:0] peek(input logic [15:0] a);
    return wr_mask[a] ? mem[a] : rom(a);
  endfunction

  // Synchronous memory: write on we, registered read data one cycle later
  always @(posedge clk) begin
    if (dma_mem_en) begin
      if (dma_mem_we) begin
        mem[dma_mem_addr]     <= dma_mem_wdata;
        wr_mask[dma_mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= peek(dma_mem_addr);
      end
    end
  end

  function automatic vec_t mk(input logic r, c, input logic [15:0] s, d,
                              input logic [7:0] l, input logic a, q,
                              input logic rdy, bsy, dn, gr, en, we,
                              input logic [15:0] ad, wd, input logic [7:0] xl);
    vec_t v;
    v.rst = r; v.cv = c; v.src = s; v.dst = d; v.len = l; v.ab = a; v.cr = q;
    v.e.rdy = rdy; v.e.bsy = bsy; v.e.dn = dn; v.e.gr = gr; v.e.en = en;
    v.e.we = we; v.e.addr = ad; v.e.wd = wd; v.e.xl = xl;
    return v;
  endfunction

  vec_t vq[$];
  exp_t got;
  int   lat;
  logic [15:0] chk_a [13];
  logic [15:0] chk_d [13];

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    abort = 1'b0; cpu_mem_req = 1'b0; mem_rdata = '0;

    // Reset state
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    // Basic copy 0x10 -> 0x40, 3 words; a cfg_valid while busy is ignored (row c4)
    vq.push_back(mk(0,1,'h10,'h40,3,0,0, 1,0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h10,0,3));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,3));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'h40,'hAAAA,3));
    vq.push_back(mk(0,1,'h999,'h777,9,0,0, 0,1,0,0,1,0,'h11,0,2));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,2));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'h41,'hBBBB,2));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h12,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'h42,'hCCCC,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    // Zero length
    vq.push_back(mk(0,1,'h100,'h200,0,0,0, 1,0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    // CPU contention: 4 blocked cycles then a forced grant, for both RD and WR
    vq.push_back(mk(0,1,'h10,'h80,1,0,1, 1,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0,0,0,0,0,0,1, 0,1,0,1,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,1, 0,1,0,0,1,0,'h10,0,1));
    vq.push_back(mk(0,0,0,0,0,0,1, 0,1,0,1,0,0,0,0,1));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0,0,0,0,0,0,1, 0,1,0,1,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,1, 0,1,0,0,1,1,'h80,'hAAAA,1));
    vq.push_back(mk(0,0,0,0,0,0,1, 0,1,1,1,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    // Address wrap
    vq.push_back(mk(0,1,'hFFFF,'hFFFE,3,0,0, 1,0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'hFFFF,0,3));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,3));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'hFFFE,'h1111,3));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h0000,0,2));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,2));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'hFFFF,'h2222,2));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h0001,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'h0000,'h3333,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    // Abort in the WR of word 2
    vq.push_back(mk(0,1,'h20,'h60,5,0,0, 1,0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h20,0,5));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,5));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'h60,'h5001,5));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h21,0,4));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,4));
    vq.push_back(mk(0,0,0,0,0,1,0, 0,1,0,0,0,0,0,0,4));
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,4));
    vq.push_back(mk(0,0,0,0,0,0,1, 1,0,0,1,0,0,0,0,4));
    // Reset during RWAIT, then cfg+abort together in IDLE, abort in FIN ignored
    vq.push_back(mk(0,1,'h10,'hA0,2,0,0, 1,0,0,0,0,0,0,0,4));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h10,0,2));
    vq.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,2));
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,'h11,'hB0,1,1,0, 1,0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,0,'h11,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,1,1,'hB0,'hBBBB,1));
    vq.push_back(mk(0,0,0,0,0,1,0, 0,1,1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));

    repeat (2) @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; cfg_valid = vq[i].cv; cfg_src = vq[i].src;
      cfg_dst = vq[i].dst; cfg_len = vq[i].len; abort = vq[i].ab;
      cpu_mem_req = vq[i].cr;
      #1;
      got = exp_t'({cfg_ready, busy, done, cpu_grant, dma_mem_en, dma_mem_we,
                    dma_mem_addr, dma_mem_wdata, xfer_left});
      n_checks++;
      if (got !== vq[i].e) begin
        n_fail++;
        $display("FAIL row%0d: got rdy=%b bsy=%b done=%b gnt=%b en=%b we=%b addr=%h wd=%h left=%0d, want rdy=%b bsy=%b done=%b gnt=%b en=%b we=%b addr=%h wd=%h left=%0d",
                 i, got.rdy, got.bsy, got.dn, got.gr, got.en, got.we, got.addr, got.wd, got.xl,
                 vq[i].e.rdy, vq[i].e.bsy, vq[i].e.dn, vq[i].e.gr, vq[i].e.en, vq[i].e.we,
                 vq[i].e.addr, vq[i].e.wd, vq[i].e.xl);
      end
    end

    // Done latency: 3-word copy must pulse done exactly 10 cycles after accept
    @(negedge clk);
    rst = 1'b0; abort = 1'b0; cpu_mem_req = 1'b0;
    cfg_valid = 1'b1; cfg_src = 16'h0010; cfg_dst = 16'h0050; cfg_len = 8'd3;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    lat = 1;
    #1;
    while (!done && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat != 10 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_latency: got %0d cycles (done=%b), want 10", lat, done);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || done !== 1'b0 || xfer_left !== 8'd0) begin
      n_fail++;
      $display("FAIL post_done: got rdy=%b done=%b left=%0d, want rdy=1 done=0 left=0",
               cfg_ready, done, xfer_left);
    end

    // Final memory image
    chk_a[0]  = 16'h0040; chk_d[0]  = 16'hAAAA;
    chk_a[1]  = 16'h0041; chk_d[1]  = 16'hBBBB;
    chk_a[2]  = 16'h0042; chk_d[2]  = 16'hCCCC;
    chk_a[3]  = 16'h0080; chk_d[3]  = 16'hAAAA;
    chk_a[4]  = 16'hFFFE; chk_d[4]  = 16'h1111;
    chk_a[5]  = 16'hFFFF; chk_d[5]  = 16'h2222;
    chk_a[6]  = 16'h0000; chk_d[6]  = 16'h3333;
    chk_a[7]  = 16'h0060; chk_d[7]  = 16'h5001;
    chk_a[8]  = 16'h0061; chk_d[8]  = 16'hDEAD;
    chk_a[9]  = 16'h00A0; chk_d[9]  = 16'hDEAD;
    chk_a[10] = 16'h00B0; chk_d[10] = 16'hBBBB;
    chk_a[11] = 16'h0050; chk_d[11] = 16'hAAAA;
    chk_a[12] = 16'h0052; chk_d[12] = 16'hCCCC;
    for (int i = 0; i < 13; i++) begin
      n_checks++;
      if (peek(chk_a[i]) !== chk_d[i]) begin
        n_fail++;
        $display("FAIL mem[%h]: got %h, want %h", chk_a[i], peek(chk_a[i]), chk_d[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ast_dma_ctrl.md
Name: ast_dma_ctrl

Overview:
DMA sequencer and memory-port arbiter serving the CFGDMA instruction. The CU supplies a source address, a destination address and a word count. The block then copies words one at a time through the single shared data-memory port. The CPU has priority on that port, and a starvation guard guarantees the DMA makes forward progress.

Parameters:
AW, 16, address width (bits)
DW, 16, data word width (bits)
LENW, 8, transfer-length width (bits)
STARVE_MAX, 4, consecutive blocked DMA cycles before the DMA is forced one grant

Ports:
Clock_pin  in  1  system clock, all logic on rising edge
Reset_pin  in  1  synchronous reset, active-high
cfg_valid  in  1  CU requests a transfer (CFGDMA executed)
cfg_ready  out  1  block idle and able to accept a configuration
cfg_src  in  AW  source start address
cfg_dst  in  AW  destination start address
cfg_len  in  LENW  number of words to copy
abort  in  1  cancel the transfer in progress
cpu_mem_req  in  1  CPU wants the memory port this cycle
cpu_grant  out  1  CPU owns the memory port this cycle (combinational)
dma_mem_en  out  1  DMA drives the memory port this cycle
dma_mem_we  out  1  DMA access is a write
dma_mem_addr  out  AW  DMA access address
dma_mem_wdata  out  DW  DMA write data
mem_rdata  in  DW  memory read data, valid one cycle after a read is issued
busy  out  1  transfer in progress (state not IDLE)
done  out  1  one-cycle pulse when a transfer completes normally
xfer_left  out  LENW  words still to copy

Behaviour:
- Interface: one clock (Clock_pin). Reset (Reset_pin) is synchronous and active-high.
- Reset values: state=IDLE, cfg_ready=1, busy=0, done=0, dma_mem_en=0, dma_mem_we=0, dma_mem_addr=0, dma_mem_wdata=0, xfer_left=0, starve counter=0.
- States: IDLE, RD, RWAIT, WR, FIN.
- Handshake: a configuration is accepted when cfg_valid && cfg_ready (cfg_ready = state==IDLE).
  - On accept, the block latches src, dst and len, and xfer_left<=cfg_len.
  - Next state is RD, or FIN if cfg_len==0.
  - cfg_valid while busy is ignored; it is neither queued nor an error.
- Arbitration (evaluated in RD and WR only):
  - force = (starve_cnt==STARVE_MAX).
  - dma_go = !cpu_mem_req || force.
  - cpu_grant = cpu_mem_req && !(dma_pending && force), where dma_pending = state in {RD,WR}.
  - dma_mem_en = dma_pending && dma_go.
  - starve_cnt increments each cycle dma_pending && !dma_go, and clears on any DMA grant or in IDLE.
- RD: when granted, drive addr=src with we=0, then go to RWAIT. When not granted, hold in RD.
- RWAIT: capture mem_rdata into the internal data buffer, then go to WR.
  - This state never touches the port; cpu_grant = cpu_mem_req.
- WR: when granted, drive addr=dst, we=1, wdata=buffer. Then:
  - src<=src+1, dst<=dst+1, with wrap modulo 2^AW.
  - xfer_left<=xfer_left-1.
  - Next state is FIN if xfer_left==1, else RD.
- FIN: done=1 for exactly one cycle, then go to IDLE. cfg_ready rises the cycle after done.
- Throughput: 3 cycles per word when uncontended. Accept to first read costs 1 cycle.
- Abort:
  - Honoured in RD, RWAIT and WR. The block goes to IDLE next cycle with dma_mem_en=0 in that cycle.
  - No done pulse. xfer_left keeps its value for inspection.
  - A write in the abort cycle is suppressed.
  - Abort in IDLE or FIN is ignored.
- Reset mid-transfer: same effect as abort, plus every register returns to its reset value.
- Simultaneous cfg_valid and abort in IDLE: the configuration is accepted.
- In IDLE, RWAIT and FIN, cpu_grant = cpu_mem_req.

Test Plan:
- Basic copy: src=0x0010, dst=0x0040, len=3, cpu_mem_req=0, memory preloaded 0xAAAA/0xBBBB/0xCCCC → writes to 0x40..0x42 with the same data, one write every 3 cycles, done pulses once 10 cycles after accept, xfer_left=0.
- Zero length: len=0 → no dma_mem_en ever, done one cycle after accept, cfg_ready=1 the cycle after.
- CPU contention and starvation: len=1, cpu_mem_req held at 1 → DMA blocked 4 cycles, then the 5th cycle has cpu_grant=0 and dma_mem_en=1 (read). WR is again blocked 4 cycles, then forced; the copy completes.
- Address wrap: src=0xFFFF, dst=0xFFFE, len=3 → reads 0xFFFF, 0x0000, 0x0001 and writes 0xFFFE, 0xFFFF, 0x0000.
- Abort: len=5, abort asserted in the WR of word 2 → that write suppressed, IDLE next cycle, no done, xfer_left=4.
- Reset mid-operation: Reset_pin high during RWAIT → next cycle all outputs at reset values, cfg_ready=1. A new cfg is accepted normally afterwards.
